jstk2_spi_sequencer: RTL and testbench

JSTK2_SPI_SEQUENCER -- requirements
Module: jstk2_spi_sequencer

---
 rtl/jstk2_spi_sequencer_pkg.sv | 34 +++
 rtl/jstk2_spi_sequencer_spi_byte_shifter.sv | 77 +++++++
 rtl/jstk2_spi_sequencer.sv | 139 +++++++++++++
 tb/tb_jstk2_spi_sequencer.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/jstk2_spi_sequencer_pkg.sv
// Shared types and constants for the JSTK2 SPI sequencer: FSM states,
// default timing parameters, joystick command bytes and the decoded result.
package jstk2_spi_sequencer_pkg;

    localparam int DEF_CLK_DIV    = 50;
    localparam int DEF_T_CS_SETUP = 1500;
    localparam int DEF_T_BYTE_GAP = 1000;

    localparam logic [7:0] CMD_POLL    = 8'h80;
    localparam logic [7:0] CMD_SET_LED = 8'h84;

    typedef enum logic [2:0] {
        IDLE,
        CS_REQ,
        SETUP,
        SHIFT,
        GAP,
        CS_REL,
        DONE
    } state_t;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic [2:0] btn;
    } jstk_result_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/jstk2_spi_sequencer_spi_byte_shifter.sv
// One SPI mode-0 byte, MSB first: SCLK low for CLK_DIV cycles then high for CLK_DIV.
// o_done is a strobe in the final high cycle, when o_rx_data already holds all 8 bits.
module spi_byte_shifter
    import jstk2_spi_sequencer_pkg::*;
#(
    parameter int CLK_DIV = DEF_CLK_DIV
) (
    input  logic       i_clk,
    input  logic       i_n_reset,
    input  logic       i_start,
    input  logic [7:0] i_data,
    input  logic       i_miso,
    output logic       o_sclk,
    output logic       o_mosi,
    output logic       o_done,
    output logic [7:0] o_rx_data
);

    localparam int DW = $clog2(CLK_DIV);

    logic          r_active;
    logic          r_sclk;
    logic          r_mosi;
    logic [DW-1:0] r_div;
    logic [2:0]    r_bit;
    logic [7:0]    r_tx;
    logic [7:0]    r_rx;
    logic          w_phase_end;

    assign w_phase_end = r_active && (r_div == DW'(CLK_DIV - 1));
    assign o_done      = w_phase_end && r_sclk && (r_bit == 3'd7);
    assign o_sclk      = r_sclk;
    assign o_mosi      = r_mosi;
    assign o_rx_data   = r_rx;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge i_clk or negedge i_n_reset) begin
        if (!i_n_reset) begin
            r_active <= 1'b0;
            r_sclk   <= 1'b0;
            r_mosi   <= 1'b0;
            r_div    <= '0;
            r_bit    <= '0;
            r_tx     <= '0;
            r_rx     <= '0;
        end else if (!r_active) begin
            if (i_start) begin
                r_active <= 1'b1;
                r_tx     <= i_data;
                r_mosi   <= i_data[7];
                r_div    <= '0;
                r_bit    <= '0;
                r_sclk   <= 1'b0;
            end
        end else if (!w_phase_end) begin
            r_div <= r_div + 1'b1;
        end else begin
            r_div <= '0;
            if (!r_sclk) begin
                // MISO is captured on the same edge that raises SCLK.
                r_sclk <= 1'b1;
                r_rx   <= {r_rx[6:0], i_miso};
            end else if (r_bit == 3'd7) begin
                r_active <= 1'b0;
                r_sclk   <= 1'b0;
                r_mosi   <= 1'b0;
            end else begin
                r_sclk <= 1'b0;
                r_bit  <= r_bit + 3'd1;
                r_tx   <= {r_tx[6:0], 1'b0};
                r_mosi <= r_tx[6];
            end
        end
    end

endmodule

// File: rtl/jstk2_spi_sequencer.sv
// JSTK2 transaction sequencer: chip-select handshake, five SPI bytes with
// setup and inter-byte delays, and decode of the joystick position/buttons.
module jstk2_spi_sequencer
    import jstk2_spi_sequencer_pkg::*;
#(
    parameter int CLK_DIV    = DEF_CLK_DIV,
    parameter int T_CS_SETUP = DEF_T_CS_SETUP,
    parameter int T_BYTE_GAP = DEF_T_BYTE_GAP
) (
    input  logic        i_clk,
    input  logic        i_n_reset,
    input  logic        i_start,
    input  logic [39:0] i_tx_data,
    output logic        o_cs_low_set,
    output logic        o_cs_high_set,
    input  logic        i_cs_low_ack,
    input  logic        i_cs_high_ack,
    output logic        o_sclk,
    output logic        o_mosi,
    input  logic        i_miso,
    output logic [9:0]  o_x,
    output logic [9:0]  o_y,
    output logic [2:0]  o_btn,
    output logic        o_busy,
    output logic        o_done
);

    localparam int TW = $clog2(max3(CLK_DIV, T_CS_SETUP, T_BYTE_GAP));

    state_t       r_state;
    logic [TW-1:0] r_timer;
    logic [2:0]   r_byte_cnt;
    logic [39:0]  r_tx_sr;
    jstk_result_t r_res;
    logic         r_cs_low_set;
    logic         r_cs_high_set;
    logic         r_busy;
    logic         r_done;
    logic [9:0]   r_x;
    logic [9:0]   r_y;
    logic [2:0]   r_btn;

    logic         w_shift_start;
    logic         w_byte_done;
    logic [7:0]   w_rx_byte;

    // The shifter is kicked in the last SETUP/GAP cycle so MOSI is valid on SHIFT entry.
    assign w_shift_start = ((r_state == SETUP) || (r_state == GAP)) && (r_timer == '0);

    spi_byte_shifter #(.CLK_DIV(CLK_DIV)) u_shifter (
        .i_clk     (i_clk),
        .i_n_reset (i_n_reset),
        .i_start   (w_shift_start),
        .i_data    (r_tx_sr[39:32]),
        .i_miso    (i_miso),
        .o_sclk    (o_sclk),
        .o_mosi    (o_mosi),
        .o_done    (w_byte_done),
        .o_rx_data (w_rx_byte)
    );

    assign o_cs_low_set  = r_cs_low_set;
    assign o_cs_high_set = r_cs_high_set;
    assign o_busy        = r_busy;
    assign o_done        = r_done;
    assign o_x           = r_x;
    assign o_y           = r_y;
    assign o_btn         = r_btn;

    always_ff @(posedge i_clk or negedge i_n_reset) begin
        if (!i_n_reset) begin
            r_state       <= IDLE;
            r_timer       <= '0;
            r_byte_cnt    <= '0;
            r_tx_sr       <= '0;
            r_res         <= '0;
            r_cs_low_set  <= 1'b0;
            r_cs_high_set <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_x           <= '0;
            r_y           <= '0;
            r_btn         <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: if (i_start) begin
                    r_tx_sr      <= i_tx_data;
                    r_byte_cnt   <= '0;
                    r_cs_low_set <= 1'b1;
                    r_busy       <= 1'b1;
                    r_state      <= CS_REQ;
                end
                CS_REQ: if (i_cs_low_ack) begin
                    r_timer <= TW'(T_CS_SETUP - 1);
                    r_state <= SETUP;
                end
                SETUP, GAP: if (r_timer == '0) begin
                    r_tx_sr <= {r_tx_sr[31:0], 8'h00};
                    r_state <= SHIFT;
                end else begin
                    r_timer <= r_timer - 1'b1;
                end
                SHIFT: if (w_byte_done) begin
                    case (r_byte_cnt)
                        3'd0:    r_res.x[7:0] <= w_rx_byte;
                        3'd1:    r_res.x[9:8] <= w_rx_byte[1:0];
                        3'd2:    r_res.y[7:0] <= w_rx_byte;
                        3'd3:    r_res.y[9:8] <= w_rx_byte[1:0];
                        default: r_res.btn    <= w_rx_byte[2:0];
                    endcase
                    if (r_byte_cnt == 3'd4) begin
                        r_cs_low_set  <= 1'b0;
                        r_cs_high_set <= 1'b1;
                        r_state       <= CS_REL;
                    end else begin
                        r_byte_cnt <= r_byte_cnt + 3'd1;
                        r_timer    <= TW'(T_BYTE_GAP - 1);
                        r_state    <= GAP;
                    end
                end
                CS_REL: if (i_cs_high_ack) begin
                    r_cs_high_set <= 1'b0;
                    r_done        <= 1'b1;
                    r_x           <= r_res.x;
                    r_y           <= r_res.y;
                    r_btn         <= r_res.btn;
                    r_state       <= DONE;
                end
                DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_jstk2_spi_sequencer.sv
// Directed bench for jstk2_spi_sequencer with a chip-select echo model, a MISO
// slave model and a scoreboard of expected MOSI stream and decoded results.
module tb_jstk2_spi_sequencer;
    import jstk2_spi_sequencer_pkg::*;

    localparam int CLK_DIV = 2;
    localparam int T_SETUP = 4;
    localparam int T_GAP   = 3;

    typedef struct {
        logic [39:0] mosi;
        logic [9:0]  x;
        logic [9:0]  y;
        logic [2:0]  btn;
    } exp_t;

    logic        clk = 1'b0;
    logic        n_reset = 1'b0;
    logic        start = 1'b0;
    logic [39:0] tx_data = '0;
    logic        cs_low_set, cs_high_set;
    logic        cs_low_ack = 1'b0, cs_high_ack = 1'b0;
    logic        sclk, mosi, miso;
    logic [9:0]  x, y;
    logic [2:0]  btn;
    logic        busy, done;

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    exp_t        expq[$];
    int          rises[$];
    logic [7:0]  slave_bytes [5];
    int          miso_idx = 0;
    logic [39:0] mosi_cap = '0;
    int          done_cnt = 0, mosi_viol = 0, cs_viol = 0, cs_falls = 0;
    int          ack_cyc = 0, cs_fall_cyc = 0;
    logic        ack_hold = 1'b0, stale_force = 1'b0;
    logic        prev_sclk = 1'b0, prev_mosi = 1'b0, prev_cs_low = 1'b0;

    jstk2_spi_sequencer #(.CLK_DIV(CLK_DIV), .T_CS_SETUP(T_SETUP), .T_BYTE_GAP(T_GAP)) dut (
        .i_clk         (clk),
        .i_n_reset     (n_reset),
        .i_start       (start),
        .i_tx_data     (tx_data),
        .o_cs_low_set  (cs_low_set),
        .o_cs_high_set (cs_high_set),
        .i_cs_low_ack  (cs_low_ack),
        .i_cs_high_ack (cs_high_ack),
        .o_sclk        (sclk),
        .o_mosi        (mosi),
        .i_miso        (miso),
        .o_x           (x),
        .o_y           (y),
        .o_btn         (btn),
        .o_busy        (busy),
        .o_done        (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign miso = (miso_idx < 40) ? slave_bytes[miso_idx / 8][7 - (miso_idx % 8)] : 1'b0;

    // Bus monitor and chip-select stage model, both evaluated mid-cycle.
    always @(negedge clk) begin
        if (!prev_sclk && sclk) begin
            rises.push_back(cyc);
            mosi_cap = {mosi_cap[38:0], mosi};
            miso_idx++;
        end
        if (sclk && (mosi !== prev_mosi)) mosi_viol++;
        if (sclk && !cs_low_set) cs_viol++;
        if (prev_cs_low && !cs_low_set) begin
            cs_falls++;
            cs_fall_cyc = cyc;
        end
        if (done) done_cnt++;
        prev_sclk   = sclk;
        prev_mosi   = mosi;
        prev_cs_low = cs_low_set;
        if (!cs_low_ack && cs_low_set && !ack_hold) ack_cyc = cyc;
        cs_low_ack  = cs_low_set && !ack_hold;
        cs_high_ack = cs_high_set || stale_force;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic launch(input logic [39:0] tx, input logic [7:0] r0, input logic [7:0] r1,
                          input logic [7:0] r2, input logic [7:0] r3, input logic [7:0] r4);
        exp_t e;
        @(negedge clk);
        slave_bytes[0] = r0; slave_bytes[1] = r1; slave_bytes[2] = r2;
        slave_bytes[3] = r3; slave_bytes[4] = r4;
        miso_idx = 0; mosi_cap = '0; rises.delete();
        done_cnt = 0; mosi_viol = 0; cs_viol = 0; cs_falls = 0;
        e.mosi = tx;
        e.x    = {r1[1:0], r0};
        e.y    = {r3[1:0], r2};
        e.btn  = r4[2:0];
        expq.push_back(e);
        tx_data = tx;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_rises(input int n, input string tag);
        for (int k = 0; k < 2000 && rises.size() < n; k++) @(negedge clk);
        check({tag, "_reach_bit"}, 64'(rises.size() >= n), 1);
    endtask

    task automatic finish_txn(input string tag);
        logic got;
        exp_t e;
        int   bad;
        got = 1'b0;
        for (int k = 0; k < 2000 && !got; k++) begin
            @(negedge clk);
            if (done) got = 1'b1;
        end
        check({tag, "_done_seen"}, got, 1);
        e = expq.pop_front();
        check({tag, "_x"}, x, e.x);
        check({tag, "_y"}, y, e.y);
        check({tag, "_btn"}, btn, e.btn);
        @(negedge clk);
        check({tag, "_done_one_cycle"}, done, 0);
        check({tag, "_busy_after"}, busy, 0);
        check({tag, "_idle_sclk_mosi"}, {sclk, mosi}, 0);
        check({tag, "_mosi_stream"}, mosi_cap, e.mosi);
        check({tag, "_bit_count"}, rises.size(), 40);
        check({tag, "_done_pulses"}, done_cnt, 1);
        check({tag, "_mosi_change_while_high"}, mosi_viol, 0);
        check({tag, "_cs_falls"}, cs_falls, 1);
        check({tag, "_sclk_without_cs"}, cs_viol, 0);
        if (rises.size() == 40) begin
            check({tag, "_ack_to_first_rise"}, 64'(rises[0] - ack_cyc), 1 + T_SETUP + CLK_DIV);
            bad = 0;
            for (int i = 1; i < 40; i++)
                if (rises[i] - rises[i-1] != ((i % 8 == 0) ? 2*CLK_DIV + T_GAP : 2*CLK_DIV)) bad++;
            check({tag, "_bit_gap_timing"}, bad, 0);
            check({tag, "_cs_held_to_end"}, 64'(cs_fall_cyc > rises[39]), 1);
        end
    endtask

    initial begin
        int bad;
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_cs", {cs_low_set, cs_high_set}, 0);
        check("rst_spi", {sclk, mosi}, 0);
        check("rst_status", {busy, done}, 0);
        check("rst_result", {x, y, btn}, 0);
        n_reset = 1'b1;
        repeat (2) @(negedge clk);

        // Basic transaction
        launch({CMD_SET_LED, 8'hFF, 8'h00, CMD_POLL, 8'h00}, 8'h34, 8'h02, 8'hCD, 8'h01, 8'h05);
        finish_txn("basic");
        check("basic_x_const", x, 10'h234);
        check("basic_y_const", y, 10'h1CD);
        check("basic_btn_const", btn, 3'd5);

        // Start pulses while busy in SHIFT and in GAP
        launch(40'h80_12_34_56_78, 8'hAB, 8'h03, 8'h5A, 8'h02, 8'h07);
        wait_rises(3, "busy_shift");
        tx_data = 40'hDE_AD_BE_EF_55;
        start = 1'b1; @(negedge clk); start = 1'b0;
        wait_rises(8, "busy_gap");
        repeat (2) @(negedge clk);
        start = 1'b1; @(negedge clk); start = 1'b0;
        finish_txn("busy");
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (busy || cs_low_set) bad++;
        end
        check("busy_no_second_txn", bad, 0);

        // Delayed chip-select acknowledge
        ack_hold = 1'b1;
        launch({CMD_POLL, 32'h0}, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h02);
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (sclk || mosi || !busy || !cs_low_set) bad++;
        end
        check("ack_wait_hold", bad, 0);
        ack_hold = 1'b0;
        finish_txn("ack");

        // Reset during byte 2
        launch(40'h84_11_22_33_44, 8'h10, 8'h01, 8'h20, 8'h02, 8'h03);
        wait_rises(18, "rst_mid");
        #2;
        n_reset = 1'b0;
        #1;
        check("abort_cs", {cs_low_set, cs_high_set}, 0);
        check("abort_spi", {sclk, mosi}, 0);
        check("abort_status", {busy, done}, 0);
        check("abort_result", {x, y, btn}, 0);
        void'(expq.pop_back());
        repeat (4) @(negedge clk);
        check("abort_no_done", done_cnt, 0);
        n_reset = 1'b1;
        repeat (2) @(negedge clk);
        launch({CMD_SET_LED, 8'hFF, 8'h00, CMD_POLL, 8'h00}, 8'h34, 8'h02, 8'hCD, 8'h01, 8'h05);
        finish_txn("after_rst");

        // Stale high acknowledge during SHIFT
        launch(40'h84_00_FF_80_01, 8'h12, 8'h01, 8'h34, 8'h03, 8'h03);
        wait_rises(5, "stale");
        stale_force = 1'b1;
        repeat (6) @(negedge clk);
        stale_force = 1'b0;
        finish_txn("stale");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
